difftest_commit_tracker: RTL and testbench

//  Sits directly upstream of the difftest DPI signal module. Takes per-cycle retire

---
 rtl/difftest_commit_tracker.sv | 97 +++++++++
 tb/tb_difftest_commit_tracker.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/difftest_commit_tracker.sv
// Delays core retire events by DELAY cycles before handing them to the difftest
// signal module; also tracks retired count, ebreak halt and commit-starvation hang.
module difftest_commit_tracker #(
   parameter int DELAY   = 2,
   parameter int TIMEOUT = 4096,
   parameter int CNT_W   = 64
) (
   input  logic             clock,
   input  logic             reset_n,
   input  logic             commit_valid,
   input  logic [31:0]      commit_pc,
   input  logic             commit_skip,
   input  logic             commit_halt,
   output logic             dt_enable,
   output logic [31:0]      dt_pc,
   output logic             dt_skip,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             halted,
   output logic             hang
);
   localparam int                IDLE_W    = $clog2(TIMEOUT + 1);
   localparam logic [IDLE_W-1:0] L_TIMEOUT = IDLE_W'(TIMEOUT);

   logic              r_vld [DELAY];
   logic [31:0]       r_pc  [DELAY];
   logic              r_skp [DELAY];
   logic [IDLE_W-1:0] r_idle;
   logic              w_accept;
   logic              w_hang_hit;

   // halted is the pre-edge value, so the ebreak commit itself is still accepted
   assign w_accept   = commit_valid && !halted;
   assign w_hang_hit = !halted && !w_accept && (r_idle == L_TIMEOUT - IDLE_W'(1));

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < DELAY; i++) begin
            r_vld[i] <= 1'b0;
            r_pc[i]  <= 32'd0;
            r_skp[i] <= 1'b0;
         end
      end else begin
         r_vld[0] <= w_accept;
         r_pc[0]  <= commit_pc;
         r_skp[0] <= commit_skip;
         for (int i = 1; i < DELAY; i++) begin
            r_vld[i] <= r_vld[i-1];
            r_pc[i]  <= r_pc[i-1];
            r_skp[i] <= r_skp[i-1];
         end
      end
   end

   // dt_pc/dt_skip only update on delivery so they hold between pulses
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         dt_enable <= 1'b0;
         dt_pc     <= 32'd0;
         dt_skip   <= 1'b0;
      end else begin
         dt_enable <= r_vld[DELAY-1];
         if (r_vld[DELAY-1]) begin
            dt_pc   <= r_pc[DELAY-1];
            dt_skip <= r_skp[DELAY-1];
         end
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         retired_cnt <= '0;
         halted      <= 1'b0;
      end else if (w_accept) begin
         retired_cnt <= retired_cnt + CNT_W'(1);
         if (commit_halt) begin
            halted <= 1'b1;
         end
      end
   end

   // idle counter saturates at TIMEOUT and is frozen once halted
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_idle <= '0;
         hang   <= 1'b0;
      end else begin
         if (w_accept) begin
            r_idle <= '0;
         end else if (!halted && (r_idle != L_TIMEOUT)) begin
            r_idle <= r_idle + IDLE_W'(1);
         end
         if (w_hang_hit) begin
            hang <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_difftest_commit_tracker.sv
// Randomized and directed bench for difftest_commit_tracker against a queue-based
// model of delivery times, retired count, halt and hang.
module tb_difftest_commit_tracker;
   localparam int DELAY   = 2;
   localparam int TIMEOUT = 16;
   localparam int CNT_W   = 4;

   logic             clock = 1'b0;
   logic             reset_n = 1'b0;
   logic             commit_valid = 1'b0;
   logic [31:0]      commit_pc = 32'd0;
   logic             commit_skip = 1'b0;
   logic             commit_halt = 1'b0;
   logic             dt_enable;
   logic [31:0]      dt_pc;
   logic             dt_skip;
   logic [CNT_W-1:0] retired_cnt;
   logic             halted;
   logic             hang;

   difftest_commit_tracker #(.DELAY(DELAY), .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
      .clock(clock), .reset_n(reset_n), .commit_valid(commit_valid),
      .commit_pc(commit_pc), .commit_skip(commit_skip), .commit_halt(commit_halt),
      .dt_enable(dt_enable), .dt_pc(dt_pc), .dt_skip(dt_skip),
      .retired_cnt(retired_cnt), .halted(halted), .hang(hang)
   );

   always #5 clock = ~clock;

   int checks = 0;
   int failures = 0;

   // Reference model: each accepted commit is scheduled for delivery at cycle+DELAY
   typedef struct {
      int          due;
      logic [31:0] pc;
      logic        skip;
   } ent_t;
   ent_t        q[$];
   int          cyc = 0;
   logic        m_en;
   logic [31:0] m_pc;
   logic        m_skip;
   int          m_cnt;
   logic        m_halted;
   logic        m_hang;
   int          m_idle;

   task model_clear();
      q.delete();
      m_en = 0; m_pc = 0; m_skip = 0; m_cnt = 0;
      m_halted = 0; m_hang = 0; m_idle = 0;
   endtask

   task step(input logic v, input logic [31:0] pc, input logic s, input logic h);
      logic acc;
      commit_valid = v; commit_pc = pc; commit_skip = s; commit_halt = h;
      @(posedge clock);
      cyc++;
      acc  = v && !m_halted;
      m_en = 0;
      if (q.size() > 0 && q[0].due == cyc) begin
         m_en = 1; m_pc = q[0].pc; m_skip = q[0].skip;
         void'(q.pop_front());
         $display("cyc %0d expect delivery pc=%h skip=%0d", cyc, m_pc, m_skip);
      end
      if (acc) begin
         q.push_back('{cyc + DELAY, pc, s});
         m_cnt  = (m_cnt + 1) % (1 << CNT_W);
         m_idle = 0;
         if (h) m_halted = 1;
      end else if (!m_halted) begin
         m_idle++;
         if (m_idle >= TIMEOUT) m_hang = 1;
      end
      #1;
   endtask

   task do_reset();
      reset_n = 1'b0;
      commit_valid = 0; commit_skip = 0; commit_halt = 0;
      repeat (2) @(posedge clock);
      #2;
      reset_n = 1'b1;
      model_clear();
   endtask

   task test_reset();
      #1;
      checks++;
      if ({dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang} !== '0) begin
         failures++;
         $display("FAIL reset_initial got en=%b pc=%h skip=%b cnt=%0d halted=%b hang=%b want all 0",
                  dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang);
      end
      do_reset();
      step(1, 32'h0000_1000, 1, 0);
      step(1, 32'h0000_1004, 1, 0);
      #2 reset_n = 1'b0;
      #1;
      checks++;
      if ({dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang} !== '0) begin
         failures++;
         $display("FAIL reset_midrun got en=%b pc=%h skip=%b cnt=%0d halted=%b hang=%b want all 0",
                  dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang);
      end
      do_reset();
      for (int i = 0; i < DELAY + 3; i++) begin
         step(0, $urandom, 1, 1);
         checks++;
         if (dt_enable !== 1'b0 || retired_cnt !== '0) begin
            failures++;
            $display("FAIL reset_flush cyc=%0d got en=%b cnt=%0d want en=0 cnt=0", cyc, dt_enable, retired_cnt);
         end
      end
   endtask

   task test_pair();
      int pulses;
      logic [31:0] seen [2];
      pulses = 0;
      do_reset();
      for (int i = 0; i < 8; i++) begin
         if (i == 2)      step(1, 32'h8000_0000, 0, 0);
         else if (i == 3) step(1, 32'h8000_0004, 0, 0);
         else             step(0, 32'h0, 0, 0);
         checks++;
         if ({dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang} !== {m_en, m_pc, m_skip, CNT_W'(m_cnt), m_halted, m_hang}) begin
            failures++;
            $display("FAIL pair cyc=%0d got en=%b pc=%h skip=%b cnt=%0d want en=%b pc=%h skip=%b cnt=%0d",
                     cyc, dt_enable, dt_pc, dt_skip, retired_cnt, m_en, m_pc, m_skip, m_cnt);
         end
         if (dt_enable) begin
            if (pulses < 2) seen[pulses] = dt_pc;
            pulses++;
         end
      end
      checks++;
      if (pulses !== 2 || seen[0] !== 32'h8000_0000 || seen[1] !== 32'h8000_0004 || retired_cnt !== CNT_W'(2)) begin
         failures++;
         $display("FAIL pair_summary got pulses=%0d pc0=%h pc1=%h cnt=%0d want 2 80000000 80000004 2",
                  pulses, seen[0], seen[1], retired_cnt);
      end
   endtask

   task test_skip();
      do_reset();
      for (int i = 0; i < 9; i++) begin
         if (i == 0)      step(1, 32'ha000_0048, 1, 0);
         else if (i == 3) step(1, 32'h8000_0100, 0, 0);
         else             step(0, $urandom, 1, 0);
         checks++;
         if ({dt_enable, dt_pc, dt_skip} !== {m_en, m_pc, m_skip}) begin
            failures++;
            $display("FAIL skip cyc=%0d got en=%b pc=%h skip=%b want en=%b pc=%h skip=%b",
                     cyc, dt_enable, dt_pc, dt_skip, m_en, m_pc, m_skip);
         end
      end
   endtask

   task test_random();
      do_reset();
      for (int i = 0; i < 400; i++) begin
         step($urandom_range(0, 99) < 60, $urandom, $urandom_range(0, 1), 1'b0);
         checks++;
         if ({dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang} !== {m_en, m_pc, m_skip, CNT_W'(m_cnt), m_halted, m_hang}) begin
            failures++;
            $display("FAIL random cyc=%0d got en=%b pc=%h skip=%b cnt=%0d hang=%b want en=%b pc=%h skip=%b cnt=%0d hang=%b",
                     cyc, dt_enable, dt_pc, dt_skip, retired_cnt, hang, m_en, m_pc, m_skip, m_cnt, m_hang);
         end
      end
   endtask

   task test_wrap();
      do_reset();
      for (int i = 0; i < 17; i++) step(1, $urandom, 0, 0);
      checks++;
      if (retired_cnt !== CNT_W'(1)) begin
         failures++;
         $display("FAIL wrap got cnt=%0d want 1", retired_cnt);
      end
   endtask

   task test_hang();
      do_reset();
      for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
      checks++;
      if (hang !== 1'b0) begin
         failures++;
         $display("FAIL hang_early got hang=%b want 0", hang);
      end
      step(0, 0, 0, 0);
      checks++;
      if (hang !== 1'b1 || m_hang !== 1'b1) begin
         failures++;
         $display("FAIL hang_set got hang=%b want 1", hang);
      end
      for (int i = 0; i < DELAY + 2; i++) begin
         step(i == 0, 32'h8000_0200, 0, 0);
         checks++;
         if ({dt_enable, dt_pc, hang} !== {m_en, m_pc, 1'b1}) begin
            failures++;
            $display("FAIL hang_sticky cyc=%0d got en=%b pc=%h hang=%b want en=%b pc=%h hang=1",
                     cyc, dt_enable, dt_pc, hang, m_en, m_pc);
         end
      end
   endtask

   task test_hang_boundary();
      do_reset();
      for (int i = 0; i < TIMEOUT - 1; i++) step(0, 0, 0, 0);
      step(1, 32'h8000_0300, 0, 0);
      checks++;
      if (hang !== 1'b0) begin
         failures++;
         $display("FAIL hang_boundary got hang=%b want 0", hang);
      end
      for (int i = 0; i < TIMEOUT; i++) begin
         step(0, 0, 0, 0);
         checks++;
         if (hang !== m_hang) begin
            failures++;
            $display("FAIL hang_recount cyc=%0d got hang=%b want %b", cyc, hang, m_hang);
         end
      end
   endtask

   task test_halt();
      int pulses;
      pulses = 0;
      do_reset();
      for (int i = 0; i < TIMEOUT + 12; i++) begin
         if (i < 2)       step(1, 32'h8000_0400 + 32'(4 * i), 0, 0);
         else if (i == 2) step(1, 32'h8000_0408, 0, 1);
         else             step(1, $urandom, $urandom_range(0, 1), $urandom_range(0, 1));
         if (dt_enable) pulses++;
         checks++;
         if ({dt_enable, dt_pc, dt_skip, retired_cnt, halted, hang} !== {m_en, m_pc, m_skip, CNT_W'(m_cnt), m_halted, m_hang}) begin
            failures++;
            $display("FAIL halt cyc=%0d got en=%b pc=%h cnt=%0d halted=%b hang=%b want en=%b pc=%h cnt=%0d halted=%b hang=%b",
                     cyc, dt_enable, dt_pc, retired_cnt, halted, hang, m_en, m_pc, m_cnt, m_halted, m_hang);
         end
      end
      checks++;
      if (pulses !== 3 || retired_cnt !== CNT_W'(3) || halted !== 1'b1 || dt_pc !== 32'h8000_0408) begin
         failures++;
         $display("FAIL halt_summary got pulses=%0d cnt=%0d halted=%b pc=%h want 3 3 1 80000408",
                  pulses, retired_cnt, halted, dt_pc);
      end
   endtask

   initial begin
      model_clear();
      test_reset();
      test_pair();
      test_skip();
      test_random();
      test_wrap();
      test_hang();
      test_hang_boundary();
      test_halt();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
